// File: rtl/pipeline_pkg.sv
// Shared pipeline types: hazard FSM states, stall-need encoding and the
// hazard unit debug view.
package pipeline_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_STALL  = 2'd1,
      ST_FREEZE = 2'd2
   } hz_state_t;

   // Number of stall cycles the ID instruction needs before it may advance
   localparam logic [1:0] NEED_NONE = 2'd0;
   localparam logic [1:0] NEED_ONE  = 2'd1;
   localparam logic [1:0] NEED_TWO  = 2'd2;

   typedef struct packed {
      hz_state_t  state;
      hz_state_t  ret_state;
      logic [1:0] cnt;
   } hz_dbg_t;

endpackage

// File: rtl/hazard_unit.sv
// Load-use / branch hazard detection with memory-busy freeze for a 5-stage pipeline.
// Optional HAZARD_PERF_CNT_EN adds stall_cycles and flush_count counters.
module hazard_unit
   import pipeline_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] IFID_Rs,
   input  logic [REG_W-1:0] IFID_Rt,
   input  logic             IFID_uses_rt,
   input  logic             IFID_branch,
   input  logic             branch_taken,
   input  logic             IDEX_mem_read,
   input  logic             IDEX_reg_write,
   input  logic [REG_W-1:0] IDEX_dest,
   input  logic             EXMEM_mem_read,
   input  logic [REG_W-1:0] EXMEM_Rd,
   input  logic             mem_busy,
   output logic             pc_write,
   output logic             IFID_write,
   output logic             IFID_flush,
   output logic             IDEX_bubble,
   output logic             stall_active,
`ifdef HAZARD_PERF_CNT_EN
   output logic [31:0]      stall_cycles,
   output logic [31:0]      flush_count,
`endif
   output hz_dbg_t          dbg
);

   hz_state_t  state_q, state_d, ret_q, ret_d, eff_state;
   logic [1:0] cnt_q, cnt_d, need;
   logic       ex_match, mem_match;

   function automatic logic src_match(input logic [REG_W-1:0] r,
                                      input logic [REG_W-1:0] rs,
                                      input logic [REG_W-1:0] rt,
                                      input logic             uses_rt);
      return (r != '0) && ((r == rs) || (uses_rt && (r == rt)));
   endfunction

   always_comb begin
      ex_match  = src_match(IDEX_dest, IFID_Rs, IFID_Rt, IFID_uses_rt);
      mem_match = src_match(EXMEM_Rd, IFID_Rs, IFID_Rt, IFID_uses_rt);
      need      = NEED_NONE;
      if (IFID_branch && IDEX_mem_read && ex_match)
         need = NEED_TWO;
      else if (IDEX_mem_read && ex_match)
         need = NEED_ONE;
      else if (IFID_branch && IDEX_reg_write && ex_match)
         need = NEED_ONE;
      else if (IFID_branch && EXMEM_mem_read && mem_match)
         need = NEED_ONE;
   end

   // A frozen unit behaves as its remembered state once mem_busy drops, so the
   // freeze lasts exactly as long as mem_busy is high.
   always_comb begin
      eff_state   = (state_q == ST_FREEZE) ? ret_q : state_q;
      pc_write    = 1'b1;
      IFID_write  = 1'b1;
      IFID_flush  = 1'b0;
      IDEX_bubble = 1'b0;
      state_d     = eff_state;
      ret_d       = ret_q;
      cnt_d       = cnt_q;
      if (rst) begin
         pc_write    = 1'b0;
         IFID_write  = 1'b0;
         IFID_flush  = 1'b1;
         IDEX_bubble = 1'b1;
      end else if (mem_busy) begin
         pc_write   = 1'b0;
         IFID_write = 1'b0;
         state_d    = ST_FREEZE;
         if (state_q != ST_FREEZE)
            ret_d = state_q;
      end else if (eff_state == ST_STALL) begin
         pc_write    = 1'b0;
         IFID_write  = 1'b0;
         IDEX_bubble = 1'b1;
         cnt_d       = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
         state_d     = (cnt_q <= 2'd1) ? ST_RUN : ST_STALL;
      end else if (need != NEED_NONE) begin
         pc_write    = 1'b0;
         IFID_write  = 1'b0;
         IDEX_bubble = 1'b1;
         cnt_d       = need - 2'd1;
         state_d     = (need == NEED_TWO) ? ST_STALL : ST_RUN;
      end else if (branch_taken) begin
         IFID_flush = 1'b1;
      end
      stall_active = !pc_write && !rst;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         ret_q   <= ST_RUN;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= 32'd0;
         flush_count  <= 32'd0;
      end else begin
         if (stall_active)
            stall_cycles <= stall_cycles + 32'd1;
         if (IFID_flush)
            flush_count <= flush_count + 32'd1;
      end
   end
`endif

   assign dbg = '{state: state_q, ret_state: ret_q, cnt: cnt_q};

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed hazard scenarios plus random
// traffic against a remaining-stall-cycles reference model.
module tb_hazard_unit;
   import pipeline_pkg::*;

   localparam logic [4:0] O_RESET  = 5'b00110; // {pc_write,IFID_write,IFID_flush,IDEX_bubble,stall_active}
   localparam logic [4:0] O_FREEZE = 5'b00001;
   localparam logic [4:0] O_STALL  = 5'b00011;
   localparam logic [4:0] O_FLUSH  = 5'b11100;
   localparam logic [4:0] O_NORMAL = 5'b11000;

   logic       clk, rst;
   logic [4:0] IFID_Rs, IFID_Rt, IDEX_dest, EXMEM_Rd;
   logic       IFID_uses_rt, IFID_branch, branch_taken;
   logic       IDEX_mem_read, IDEX_reg_write, EXMEM_mem_read, mem_busy;
   logic       pc_write, IFID_write, IFID_flush, IDEX_bubble, stall_active;
   hz_dbg_t    dbg;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cycles, flush_count;
`endif

   int          checks = 0;
   int          errors = 0;
   int          m_pending = 0;
   int unsigned m_stall_cnt = 0;
   int unsigned m_flush_cnt = 0;
   logic [4:0]  exp_q[$];
   logic [4:0]  got, exp;

   hazard_unit #(.REG_W(5)) dut (
      .clk(clk), .rst(rst),
      .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_uses_rt(IFID_uses_rt),
      .IFID_branch(IFID_branch), .branch_taken(branch_taken),
      .IDEX_mem_read(IDEX_mem_read), .IDEX_reg_write(IDEX_reg_write),
      .IDEX_dest(IDEX_dest), .EXMEM_mem_read(EXMEM_mem_read), .EXMEM_Rd(EXMEM_Rd),
      .mem_busy(mem_busy),
      .pc_write(pc_write), .IFID_write(IFID_write), .IFID_flush(IFID_flush),
      .IDEX_bubble(IDEX_bubble), .stall_active(stall_active),
`ifdef HAZARD_PERF_CNT_EN
      .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
      .dbg(dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // reference model: pipeline needs `m_pending` more forced stall cycles
   function automatic bit src_hit(input logic [4:0] r);
      return (r != 0) && (r == IFID_Rs || (IFID_uses_rt && r == IFID_Rt));
   endfunction

   function automatic int ref_need();
      if (IFID_branch && IDEX_mem_read && src_hit(IDEX_dest)) return 2;
      if (IDEX_mem_read && src_hit(IDEX_dest)) return 1;
      if (IFID_branch && IDEX_reg_write && src_hit(IDEX_dest)) return 1;
      if (IFID_branch && EXMEM_mem_read && src_hit(EXMEM_Rd)) return 1;
      return 0;
   endfunction

   task automatic model_cycle();
      logic [4:0] e;
      int n;
      if (rst) begin
         e = O_RESET;
         m_pending = 0;
      end else if (mem_busy) begin
         e = O_FREEZE;
      end else if (m_pending > 0) begin
         e = O_STALL;
         m_pending--;
      end else begin
         n = ref_need();
         if (n > 0) begin
            e = O_STALL;
            m_pending = n - 1;
         end else if (branch_taken) e = O_FLUSH;
         else e = O_NORMAL;
      end
      if (rst) begin
         m_stall_cnt = 0;
         m_flush_cnt = 0;
      end else begin
         if (e[0]) m_stall_cnt++;
         if (e[2]) m_flush_cnt++;
      end
      exp_q.push_back(e);
   endtask

   // driver tasks
   task automatic clear_inputs();
      rst = 1'b0; IFID_Rs = 0; IFID_Rt = 0; IFID_uses_rt = 0; IFID_branch = 0;
      branch_taken = 0; IDEX_mem_read = 0; IDEX_reg_write = 0; IDEX_dest = 0;
      EXMEM_mem_read = 0; EXMEM_Rd = 0; mem_busy = 0;
   endtask

   task automatic drive_load_use(input logic [4:0] r, input logic branch);
      clear_inputs();
      IDEX_mem_read = 1; IDEX_dest = r;
      IFID_Rs = branch ? 5'd9 : r; IFID_Rt = r; IFID_uses_rt = branch;
      IFID_branch = branch;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         clear_inputs();
         rst = 1; mem_busy = 1'($urandom_range(0, 1)); branch_taken = 1;
         #1; model_cycle(); exp = exp_q.pop_front();
         got = {pc_write, IFID_write, IFID_flush, IDEX_bubble, stall_active};
         checks++;
         if (got !== exp) begin errors++; $display("FAIL reset_outputs cyc %0d got %b want %b", i, got, exp); end
      end
      @(negedge clk);
      clear_inputs();
      #1;
      checks++;
      if (dbg.state !== ST_RUN || dbg.cnt !== 2'd0) begin
         errors++; $display("FAIL reset_state got state %0d cnt %0d want 0 0", dbg.state, dbg.cnt);
      end
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if (stall_cycles !== 0 || flush_count !== 0) begin
         errors++; $display("FAIL reset_counters got %0d %0d want 0 0", stall_cycles, flush_count);
      end
`endif
      model_cycle(); exp = exp_q.pop_front();
      got = {pc_write, IFID_write, IFID_flush, IDEX_bubble, stall_active};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL reset_release got %b want %b", got, exp); end
   endtask

   // lw $5 in EX, add $5 in ID, then the bubble moves into EX
   task automatic test_load_use();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (i == 0) drive_load_use(5'd5, 1'b0);
         else clear_inputs();
         #1; model_cycle(); exp = exp_q.pop_front();
         got = {pc_write, IFID_write, IFID_flush, IDEX_bubble, stall_active};
         checks++;
         if (got !== exp) begin errors++; $display("FAIL load_use cyc %0d got %b want %b", i, got, exp); end
      end
   endtask

   // lw $8 in EX, beq reads $8 via Rt: two stall cycles with inputs held
   task automatic test_load_branch();
      int stalls = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i < 2) drive_load_use(5'd8, 1'b1);
         else clear_inputs();
         #1; model_cycle(); exp = exp_q.pop_front();
         got = {pc_write, IFID_write, IFID_flush, IDEX_bubble, stall_active};
         if (IDEX_bubble) stalls++;
         checks++;
         if (got !== exp) begin errors++; $display("FAIL load_branch cyc %0d got %b want %b", i, got, exp); end
      end
      checks++;
      if (stalls != 2) begin errors++; $display("FAIL load_branch_len got %0d want 2", stalls); end
   endtask

   task automatic test_reg_zero();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive_load_use(5'd0, 1'(i == 1));
         IFID_Rs = 0; IFID_Rt = 0; IFID_uses_rt = 1;
         IDEX_reg_write = 1; EXMEM_mem_read = 1; EXMEM_Rd = 0;
         #1; model_cycle(); exp = exp_q.pop_front();
         got = {pc_write, IFID_write, IFID_flush, IDEX_bubble, stall_active};
         checks++;
         if (got !== exp) begin errors++; $display("FAIL reg_zero cyc %0d got %b want %b", i, got, exp); end
      end
   endtask

   task automatic test_flush();
      int flushes = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         clear_inputs();
         IFID_Rs = 5'($urandom_range(1, 31)); IDEX_dest = IFID_Rs + 5'd1;
         IDEX_reg_write = 1; branch_taken = (i == 0);
         #1; model_cycle(); exp = exp_q.pop_front();
         got = {pc_write, IFID_write, IFID_flush, IDEX_bubble, stall_active};
         if (IFID_flush) flushes++;
         checks++;
         if (got !== exp) begin errors++; $display("FAIL flush cyc %0d got %b want %b", i, got, exp); end
      end
      checks++;
      if (flushes != 1) begin errors++; $display("FAIL flush_len got %0d want 1", flushes); end
   endtask

   // mem_busy for three cycles during the second cycle of a two-cycle stall
   task automatic test_freeze_in_stall();
      int freezes = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i < 5) drive_load_use(5'd8, 1'b1);
         else clear_inputs();
         mem_busy = (i >= 1 && i <= 3);
         branch_taken = (i == 4);
         #1; model_cycle(); exp = exp_q.pop_front();
         got = {pc_write, IFID_write, IFID_flush, IDEX_bubble, stall_active};
         if (stall_active && !IDEX_bubble) freezes++;
         checks++;
         if (got !== exp) begin errors++; $display("FAIL freeze_stall cyc %0d got %b want %b", i, got, exp); end
      end
      checks++;
      if (freezes != 3) begin errors++; $display("FAIL freeze_len got %0d want 3", freezes); end
   endtask

   task automatic test_reset_in_stall();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (i == 0) drive_load_use(5'd7, 1'b1);
         else clear_inputs();
         rst = (i == 1);
         #1;
         if (i == 1) begin
            checks++;
            if (dbg.state !== ST_STALL) begin errors++; $display("FAIL rst_stall_pre got state %0d want %0d", dbg.state, ST_STALL); end
         end
         if (i == 2) begin
            checks++;
            if (dbg.state !== ST_RUN || dbg.cnt !== 2'd0) begin
               errors++; $display("FAIL rst_stall_state got %0d cnt %0d want 0 0", dbg.state, dbg.cnt);
            end
`ifdef HAZARD_PERF_CNT_EN
            checks++;
            if (stall_cycles !== 0 || flush_count !== 0) begin
               errors++; $display("FAIL rst_stall_counters got %0d %0d want 0 0", stall_cycles, flush_count);
            end
`endif
         end
         model_cycle(); exp = exp_q.pop_front();
         got = {pc_write, IFID_write, IFID_flush, IDEX_bubble, stall_active};
         checks++;
         if (got !== exp) begin errors++; $display("FAIL rst_stall cyc %0d got %b want %b", i, got, exp); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         rst            = ($urandom_range(0, 49) == 0);
         mem_busy       = ($urandom_range(0, 5) == 0);
         IFID_Rs        = 5'($urandom_range(0, 3));
         IFID_Rt        = 5'($urandom_range(0, 3));
         IDEX_dest      = 5'($urandom_range(0, 3));
         EXMEM_Rd       = 5'($urandom_range(0, 3));
         IFID_uses_rt   = 1'($urandom_range(0, 1));
         IFID_branch    = 1'($urandom_range(0, 1));
         IDEX_mem_read  = 1'($urandom_range(0, 1));
         IDEX_reg_write = 1'($urandom_range(0, 1));
         EXMEM_mem_read = 1'($urandom_range(0, 1));
         branch_taken   = ($urandom_range(0, 3) == 0);
         #1;
`ifdef HAZARD_PERF_CNT_EN
         checks++;
         if (stall_cycles !== m_stall_cnt || flush_count !== m_flush_cnt) begin
            errors++;
            $display("FAIL rand_counters cyc %0d got %0d %0d want %0d %0d", i, stall_cycles, flush_count, m_stall_cnt, m_flush_cnt);
         end
`endif
         model_cycle(); exp = exp_q.pop_front();
         got = {pc_write, IFID_write, IFID_flush, IDEX_bubble, stall_active};
         checks++;
         if (got !== exp) begin errors++; $display("FAIL random cyc %0d got %b want %b", i, got, exp); end
      end
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;
      test_reset();
      test_load_use();
      test_load_branch();
      test_reg_zero();
      test_flush();
      test_freeze_in_stall();
      test_reset_in_stall();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
